score_keeper: RTL

- Two-player score bookkeeping stage that sits directly upstream of the seven-segment digit renderer.
- Counts points from the ball/collision logic in two-digit BCD per player and detects game end.
- Presents frame-stable tens/ones digits, latched only at frame start so a digit never changes mid-scan (no tearing).
- Each digit output drives one renderer instance's 4-bit digit input; values are always 0-9.

---
 rtl/pong_pkg.sv | 23 ++
 rtl/score_keeper_bcd_counter2.sv | 55 +++++
 rtl/score_keeper.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// pong_pkg : shared widths, winner codes and BCD helper for the score path
// Revision : 1.0
// ============================================================================
package pong_pkg;

  localparam int BCD_W  = 4;
  localparam int DISP_W = 240;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  function automatic logic [6:0] bcd2bin(input logic [BCD_W-1:0] t,
                                         input logic [BCD_W-1:0] o);
    return ({3'b000, t} * 7'd10) + {3'b000, o};
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_keeper_bcd_counter2.sv
`default_nettype none
// ============================================================================
// bcd_counter2 : two-digit BCD counter, saturating at 99, with next-value binary
// Revision : 1.0
// ============================================================================
module bcd_counter2
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic [6:0]       next_bin
);

  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] w_next_tens;
  logic [BCD_W-1:0] w_next_ones;

  always_comb begin
    w_next_tens = r_tens;
    w_next_ones = r_ones;
    if (r_tens == 4'd9 && r_ones == 4'd9) begin
      w_next_tens = r_tens;
      w_next_ones = r_ones;
    end else if (r_ones == 4'd9) begin
      w_next_ones = 4'd0;
      w_next_tens = r_tens + 4'd1;
    end else begin
      w_next_ones = r_ones + 4'd1;
    end
  end

  // Binary form of the incremented value lets the caller test for a win
  // in the same cycle the increment is committed.
  assign next_bin = bcd2bin(w_next_tens, w_next_ones);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (inc) begin
      r_tens <= w_next_tens;
      r_ones <= w_next_ones;
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// score_keeper : two-player BCD scoring, win detect and tear-free digit latch
// Revision : 1.0
// ============================================================================
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 11,
  parameter bit LATCH_ON_FRAME = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic             point_p1,
  input  logic             point_p2,
  input  logic             frame_start,
  output logic [BCD_W-1:0] p1_tens,
  output logic [BCD_W-1:0] p1_ones,
  output logic [BCD_W-1:0] p2_tens,
  output logic [BCD_W-1:0] p2_ones,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             serve_p2
);

  localparam logic [6:0] c_WIN = 7'(WIN_SCORE);

  logic             r_p1_hist;
  logic             r_p2_hist;
  logic             r_game_over;
  winner_e          r_winner;
  logic             r_serve_p2;
  logic             w_ev1;
  logic             w_ev2;
  logic             w_score1;
  logic             w_score2;
  logic [BCD_W-1:0] w_p1_tens;
  logic [BCD_W-1:0] w_p1_ones;
  logic [BCD_W-1:0] w_p2_tens;
  logic [BCD_W-1:0] w_p2_ones;
  logic [6:0]       w_p1_next;
  logic [6:0]       w_p2_next;
  logic [BCD_W-1:0] r_disp_p1_tens;
  logic [BCD_W-1:0] r_disp_p1_ones;
  logic [BCD_W-1:0] r_disp_p2_tens;
  logic [BCD_W-1:0] r_disp_p2_ones;

  assign w_ev1 = point_p1 & ~r_p1_hist;
  assign w_ev2 = point_p2 & ~r_p2_hist;

  // A tie in one cycle is ambiguous, so neither player is credited.
  assign w_score1 = w_ev1 & ~w_ev2 & ~new_game & ~r_game_over;
  assign w_score2 = w_ev2 & ~w_ev1 & ~new_game & ~r_game_over;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_hist <= 1'b0;
      r_p2_hist <= 1'b0;
    end else begin
      r_p1_hist <= point_p1;
      r_p2_hist <= point_p2;
    end
  end

  bcd_counter2 u_cnt_p1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (new_game),
    .inc      (w_score1),
    .tens     (w_p1_tens),
    .ones     (w_p1_ones),
    .next_bin (w_p1_next)
  );

  bcd_counter2 u_cnt_p2 (
    .clk      (clk),
    .rst      (rst),
    .clr      (new_game),
    .inc      (w_score2),
    .tens     (w_p2_tens),
    .ones     (w_p2_ones),
    .next_bin (w_p2_next)
  );

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      r_game_over <= 1'b0;
      r_winner    <= WIN_NONE;
      r_serve_p2  <= 1'b0;
    end else if (w_score1) begin
      r_serve_p2 <= 1'b1;
      if (w_p1_next == c_WIN) begin
        r_game_over <= 1'b1;
        r_winner    <= WIN_P1;
      end
    end else if (w_score2) begin
      r_serve_p2 <= 1'b0;
      if (w_p2_next == c_WIN) begin
        r_game_over <= 1'b1;
        r_winner    <= WIN_P2;
      end
    end
  end

  // Digits sample the counters' current (pre-update) values at frame start
  // so the renderer never sees a change mid-scan.
  generate
    if (LATCH_ON_FRAME) begin : g_frame_latch
      always_ff @(posedge clk) begin
        if (rst) begin
          r_disp_p1_tens <= '0;
          r_disp_p1_ones <= '0;
          r_disp_p2_tens <= '0;
          r_disp_p2_ones <= '0;
        end else if (frame_start) begin
          r_disp_p1_tens <= w_p1_tens;
          r_disp_p1_ones <= w_p1_ones;
          r_disp_p2_tens <= w_p2_tens;
          r_disp_p2_ones <= w_p2_ones;
        end
      end
    end else begin : g_follow
      always_ff @(posedge clk) begin
        if (rst) begin
          r_disp_p1_tens <= '0;
          r_disp_p1_ones <= '0;
          r_disp_p2_tens <= '0;
          r_disp_p2_ones <= '0;
        end else begin
          r_disp_p1_tens <= w_p1_tens;
          r_disp_p1_ones <= w_p1_ones;
          r_disp_p2_tens <= w_p2_tens;
          r_disp_p2_ones <= w_p2_ones;
        end
      end
    end
  endgenerate

  assign p1_tens   = r_disp_p1_tens;
  assign p1_ones   = r_disp_p1_ones;
  assign p2_tens   = r_disp_p2_tens;
  assign p2_ones   = r_disp_p2_ones;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign serve_p2  = r_serve_p2;

endmodule
`default_nettype wire
